dnn: RTL and testbench

DNN -- requirements
Module: dnn

---
 rtl/dnn.sv | 200 ++++++++++++++++++++
 tb/tb_dnn.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn.sv
// dnn: K x K valid-convolution engine with a host-accessible output memory.
// Optional feature: define DNN_RELU_EN to clamp negative outputs to zero before they are stored.
module dnn #(
  parameter int T          = 32,
  parameter int OMEM_DEPTH = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] ps_control,
  output logic [T-1:0] pl_status,
  input  logic [T-1:0] bias,
  input  logic [T-1:0] n_val,
  input  logic [T-1:0] c_val,
  input  logic [T-1:0] k_val,
  output logic [T-1:0] bram_i_addr,
  input  logic [T-1:0] bram_i_rddata,
  output logic [T-1:0] bram_w_addr,
  input  logic [T-1:0] bram_w_rddata,
  input  logic         bram_oc_clk,
  input  logic         bram_oc_rst,
  input  logic         bram_oc_en,
  input  logic [3:0]   bram_oc_we,
  input  logic [T-1:0] bram_oc_addr,
  input  logic [T-1:0] bram_oc_wrdata,
  output logic [T-1:0] bram_oc_rddata
);

  localparam int AW = (OMEM_DEPTH > 1) ? $clog2(OMEM_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, ACC, WRITE, DONE} state_e;

  state_e state_q, state_d;

  logic [T-1:0]    c_q, c_d, k_q, k_d, kk_q, kk_d, w_q, w_d, bias_q, bias_d;
  logic [T-1:0]    x_q, x_d, y_q, y_d, s_q, s_d;
  logic [T-1:0]    origin_q, origin_d, i_idx_q, i_idx_d, w_idx_q, w_idx_d;
  logic [AW-1:0]   o_idx_q, o_idx_d;
  logic [T-1:0]    acc_q, acc_d;
  logic [T-1:0]    i_addr_q, i_addr_d, w_addr_q, w_addr_d;
  logic            issue_q, issue_d, data_v_q, data_v_d;
  logic [T-1:0]    rddata_q, rddata_d;

  logic            start, cfg_bad, last_out, last_tap;
  logic [T:0]      w_full;
  logic [2*T+1:0]  cc_full, ww_full;
  logic [T-1:0]    sum, wr_data, host_word;
  logic            eng_we, host_we, host_in_range, busy, done;
  logic            unused_ok;

  logic [T-1:0]    omem [OMEM_DEPTH];

  assign unused_ok = ^{ps_control[T-1:1], n_val[T-1:1]};

  assign start    = ps_control[0];
  assign w_full   = (T+1)'(c_val) + (T+1)'(k_val) - (T+1)'(1);
  assign cc_full  = (2*T+2)'(c_val) * (2*T+2)'(c_val);
  assign ww_full  = (2*T+2)'(w_full) * (2*T+2)'(w_full);
  assign cfg_bad  = (k_val == '0) || (c_val == '0) ||
                    (cc_full > (2*T+2)'(OMEM_DEPTH)) || (ww_full > (2*T+2)'(1024));
  assign last_tap = (w_idx_q == kk_q - T'(1));
  assign last_out = (x_q == c_q - T'(1)) && (y_q == c_q - T'(1));

  assign sum = bias_q + acc_q;
`ifdef DNN_RELU_EN
  assign wr_data = sum[T-1] ? '0 : sum;
`else
  assign wr_data = sum;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = cfg_bad ? DONE : FETCH;
      FETCH:   if (last_tap) state_d = ACC;
      // Two cycles drain the read pipeline: last address in flight, then last product.
      ACC:     if (!issue_q) state_d = WRITE;
      WRITE:   state_d = last_out ? DONE : FETCH;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and memory write strobes
  always_comb begin
    busy          = (state_q == FETCH) || (state_q == ACC) || (state_q == WRITE);
    done          = (state_q == DONE);
    pl_status     = '0;
    pl_status[0]  = done;
    pl_status[1]  = busy;
    eng_we        = (state_q == WRITE);
    host_word     = bram_oc_addr >> 2;
    host_in_range = (host_word < T'(OMEM_DEPTH));
    host_we       = bram_oc_en && (&bram_oc_we) && host_in_range &&
                    ((state_q == IDLE) || (state_q == DONE));
  end

  // Datapath next-state
  always_comb begin
    c_d      = c_q;      k_d      = k_q;      kk_d    = kk_q;
    w_d      = w_q;      bias_d   = bias_q;
    x_d      = x_q;      y_d      = y_q;      s_d     = s_q;
    origin_d = origin_q; i_idx_d  = i_idx_q;  w_idx_d = w_idx_q;
    o_idx_d  = o_idx_q;  acc_d    = acc_q;
    i_addr_d = i_addr_q; w_addr_d = w_addr_q;
    issue_d  = (state_q == FETCH);
    data_v_d = issue_q;

    if (data_v_q) acc_d = acc_q + bram_i_rddata * bram_w_rddata;

    unique case (state_q)
      IDLE: if (start) begin
        c_d      = c_val;
        k_d      = k_val;
        kk_d     = k_val * k_val;
        w_d      = w_full[T-1:0];
        bias_d   = bias;
        x_d      = '0; y_d = '0; s_d = '0;
        origin_d = '0; i_idx_d = '0; w_idx_d = '0;
        o_idx_d  = '0; acc_d = '0;
      end
      FETCH: begin
        i_addr_d = i_idx_q << 2;
        w_addr_d = w_idx_q << 2;
        w_idx_d  = w_idx_q + T'(1);
        // Walk the K x K window: step right, or jump to the start of the next window row.
        if (s_q == k_q - T'(1)) begin
          s_d     = '0;
          i_idx_d = i_idx_q + w_q - k_q + T'(1);
        end else begin
          s_d     = s_q + T'(1);
          i_idx_d = i_idx_q + T'(1);
        end
      end
      WRITE: begin
        acc_d   = '0;
        o_idx_d = o_idx_q + AW'(1);
        w_idx_d = '0;
        s_d     = '0;
        if (x_q == c_q - T'(1)) begin
          x_d      = '0;
          y_d      = y_q + T'(1);
          origin_d = origin_q + k_q;
        end else begin
          x_d      = x_q + T'(1);
          origin_d = origin_q + T'(1);
        end
        i_idx_d = origin_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q      <= '0; k_q      <= '0; kk_q    <= '0; w_q <= '0; bias_q <= '0;
      x_q      <= '0; y_q      <= '0; s_q     <= '0;
      origin_q <= '0; i_idx_q  <= '0; w_idx_q <= '0; o_idx_q <= '0;
      acc_q    <= '0; i_addr_q <= '0; w_addr_q <= '0;
      issue_q  <= 1'b0; data_v_q <= 1'b0;
    end else begin
      c_q      <= c_d;      k_q      <= k_d;      kk_q    <= kk_d;
      w_q      <= w_d;      bias_q   <= bias_d;
      x_q      <= x_d;      y_q      <= y_d;      s_q     <= s_d;
      origin_q <= origin_d; i_idx_q  <= i_idx_d;  w_idx_q <= w_idx_d;
      o_idx_q  <= o_idx_d;  acc_q    <= acc_d;
      i_addr_q <= i_addr_d; w_addr_q <= w_addr_d;
      issue_q  <= issue_d;  data_v_q <= data_v_d;
    end
  end

  assign bram_i_addr = i_addr_q;
  assign bram_w_addr = w_addr_q;

  // Output memory is never cleared by reset; engine write takes priority.
  always_ff @(posedge clk) begin
    if (eng_we)       omem[o_idx_q]             <= wr_data;
    else if (host_we) omem[host_word[AW-1:0]] <= bram_oc_wrdata;
  end

  always_comb begin
    rddata_d = rddata_q;
    if (bram_oc_rst)     rddata_d = '0;
    else if (bram_oc_en) rddata_d = (n_val[0] && host_in_range) ? omem[host_word[AW-1:0]] : '0;
  end

  always_ff @(posedge bram_oc_clk or negedge reset) begin
    if (!reset) rddata_q <= '0;
    else        rddata_q <= rddata_d;
  end

  assign bram_oc_rddata = rddata_q;

endmodule

// File: tb/tb_dnn.sv
// Scoreboard bench for dnn: reference convolution model, host read-back through a queue-fed monitor.
`timescale 1ns/1ps
module tb_dnn;
  localparam int T  = 32;
  localparam int OD = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [T-1:0] ps_control, pl_status, bias, n_val, c_val, k_val;
  logic [T-1:0] bram_i_addr, bram_i_rddata, bram_w_addr, bram_w_rddata;
  logic         bram_oc_rst, bram_oc_en;
  logic [3:0]   bram_oc_we;
  logic [T-1:0] bram_oc_addr, bram_oc_wrdata, bram_oc_rddata;

  dnn #(.T(T), .OMEM_DEPTH(OD)) dut (
    .clk(clk), .reset(reset), .ps_control(ps_control), .pl_status(pl_status),
    .bias(bias), .n_val(n_val), .c_val(c_val), .k_val(k_val),
    .bram_i_addr(bram_i_addr), .bram_i_rddata(bram_i_rddata),
    .bram_w_addr(bram_w_addr), .bram_w_rddata(bram_w_rddata),
    .bram_oc_clk(clk), .bram_oc_rst(bram_oc_rst), .bram_oc_en(bram_oc_en),
    .bram_oc_we(bram_oc_we), .bram_oc_addr(bram_oc_addr),
    .bram_oc_wrdata(bram_oc_wrdata), .bram_oc_rddata(bram_oc_rddata)
  );

  logic [31:0] imem  [1024];
  logic [31:0] wmem  [1024];
  logic [31:0] model [OD];
  logic [31:0] snap  [OD];

  always @(posedge clk) begin
    bram_i_rddata <= imem[bram_i_addr[11:2]];
    bram_w_rddata <= wmem[bram_w_addr[11:2]];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%08h exp=%08h", name, act, exp);
    end
  endtask

  typedef struct { int word; logic [31:0] exp; } rd_t;
  rd_t  expq[$];
  logic rd_req = 1'b0;
  logic rd_v   = 1'b0;

  always @(posedge clk) rd_v <= rd_req;

  always @(negedge clk) begin : monitor
    rd_t e;
    if (rd_v) begin
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected act=%08h", bram_oc_rddata);
      end else begin
        e = expq.pop_front();
        chk($sformatf("rd[%0d]", e.word), bram_oc_rddata, e.exp);
      end
    end
  end

  task automatic host_read(input int word, input logic nv, input logic [31:0] exp);
    rd_t e;
    bram_oc_en = 1'b1; bram_oc_we = 4'h0; bram_oc_addr = 32'(word * 4);
    n_val = {31'b0, nv}; rd_req = 1'b1;
    e.word = word; e.exp = exp; expq.push_back(e);
    @(negedge clk);
    bram_oc_en = 1'b0; rd_req = 1'b0;
  endtask

  task automatic host_write(input int word, input logic [31:0] d, input bit allowed);
    bram_oc_en = 1'b1; bram_oc_we = 4'hf; bram_oc_addr = 32'(word * 4);
    bram_oc_wrdata = d; rd_req = 1'b0;
    if (allowed && word < OD) model[word] = d;
    @(negedge clk);
    bram_oc_en = 1'b0; bram_oc_we = 4'h0;
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    if (expq.size() != 0) begin
      checks++; failures++;
      $display("FAIL rd_drain act=%0d exp=0", expq.size());
      expq.delete();
    end
  endtask

  task automatic read_all(input int n);
    for (int i = 0; i < n; i++) host_read(i, 1'b1, model[i]);
    drain();
  endtask

  // Reference: o[C*y+x] = bias + sum w[K*r+s]*i[W*(y+r)+x+s], 32-bit wrap.
  task automatic model_run(input int c, input int k, input logic [31:0] b);
    int w;
    logic [31:0] acc;
    w = c + k - 1;
    for (int y = 0; y < c; y++)
      for (int x = 0; x < c; x++) begin
        acc = b;
        for (int r = 0; r < k; r++)
          for (int s = 0; s < k; s++)
            acc = acc + wmem[k*r+s] * imem[w*(y+r)+x+s];
`ifdef DNN_RELU_EN
        if (acc[31]) acc = '0;
`endif
        model[c*y+x] = acc;
      end
  endtask

  task automatic run(input int c, input int k, input logic [31:0] b, input bit poke);
    int cyc, bound, wv;
    bit bad;
    logic [31:0] prev_i, prev_w;
    wv     = c + k - 1;
    bad    = (k == 0) || (c == 0) || (c*c > OD) || (wv*wv > 1024);
    bound  = bad ? 3 : c*c*(k*k+4) + 8;
    prev_i = bram_i_addr; prev_w = bram_w_addr;
    c_val = 32'(c); k_val = 32'(k); bias = b; ps_control = 32'h1;
    @(negedge clk);
    cyc = 1;
    if (!bad) chk("busy_after_start", pl_status, 32'h2);
    c_val = $urandom; k_val = $urandom; bias = $urandom;
    if (poke) begin
      host_write(1000, 32'hdead_beef, 1'b0);
      cyc++;
    end
    while (pl_status[0] !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("done_by_bound c=%0d k=%0d", c, k), pl_status, 32'h1);
    if (bad) begin
      chk("i_addr_untouched", bram_i_addr, prev_i);
      chk("w_addr_untouched", bram_w_addr, prev_w);
    end else begin
      chk("i_addr_hold", bram_i_addr, 32'((wv*wv-1)*4));
      chk("w_addr_hold", bram_w_addr, 32'((k*k-1)*4));
      model_run(c, k, b);
    end
    repeat (2) @(negedge clk);
    chk("done_held", pl_status, 32'h1);
    ps_control = 32'h0;
    @(negedge clk);
    chk("done_cleared", pl_status, 32'h0);
  endtask

  initial begin
    reset = 1'b0; ps_control = '0; bias = '0; n_val = '0; c_val = '0; k_val = '0;
    bram_oc_rst = 1'b0; bram_oc_en = 1'b0; bram_oc_we = 4'h0;
    bram_oc_addr = '0; bram_oc_wrdata = '0;
    for (int n = 0; n < 1024; n++) begin imem[n] = 32'(n); wmem[n] = 32'h1; end

    repeat (2) @(negedge clk);
    chk("rst_status", pl_status, 32'h0);
    chk("rst_i_addr", bram_i_addr, 32'h0);
    chk("rst_w_addr", bram_w_addr, 32'h0);
    chk("rst_rddata", bram_oc_rddata, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int n = 0; n < OD; n++) host_write(n, 32'h5a5a_0000 ^ 32'(n), 1'b1);
    host_write(1100, 32'h1234_5678, 1'b1);
    host_read(1100, 1'b1, 32'h0);
    host_read(5, 1'b1, model[5]);
    host_read(6, 1'b0, 32'h0);
    host_read(7, 1'b1, model[7]);
    drain();
    bram_oc_rst = 1'b1;
    @(negedge clk);
    chk("oc_rst", bram_oc_rddata, 32'h0);
    bram_oc_rst = 1'b0;

    run(30, 3, 32'h0, 1'b1);
    host_read(0, 1'b1, 32'h129);
    host_read(1, 1'b1, 32'h132);
    host_read(30, 1'b1, 32'h249);
    read_all(OD);

    run(30, 3, 32'h5, 1'b0);
    host_read(0, 1'b1, 32'h12e);
    drain();
    for (int n = 0; n < OD; n++) snap[n] = model[n];
    run(30, 3, 32'h5, 1'b0);
    for (int n = 0; n < 900; n++) host_read(n, 1'b1, snap[n]);
    drain();

    for (int n = 0; n < 1024; n++) wmem[n] = 32'hffff_ffff;
    run(30, 3, 32'h0, 1'b0);
`ifdef DNN_RELU_EN
    host_read(0, 1'b1, 32'h0);
`else
    host_read(0, 1'b1, 32'hffff_fed7);
`endif
    read_all(900);

    for (int t = 0; t < 4; t++) begin
      int c, k;
      for (int n = 0; n < 1024; n++) begin imem[n] = $urandom; wmem[n] = $urandom; end
      c = $urandom_range(1, 8);
      k = $urandom_range(1, 5);
      run(c, k, $urandom, 1'b0);
      read_all(c*c + 4);
    end

    run(5, 0, 32'h7, 1'b0);
    run(0, 3, 32'h7, 1'b0);
    run(33, 1, 32'h7, 1'b0);
    run(20, 14, 32'h7, 1'b0);
    read_all(OD);

    c_val = 32'd5; k_val = 32'd4; bias = 32'h0; ps_control = 32'h1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_status", pl_status, 32'h0);
    chk("abort_i_addr", bram_i_addr, 32'h0);
    chk("abort_w_addr", bram_w_addr, 32'h0);
    chk("abort_rddata", bram_oc_rddata, 32'h0);
    ps_control = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_idle", pl_status, 32'h0);
    read_all(40);

    run(4, 2, 32'hffff_fff0, 1'b0);
    read_all(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
